// File: rtl/nms_layer_scheduler_if.sv
// Handshake bundle between the NMS layer scheduler and the sort/CNU datapath.
// The master modport is the scheduler side and the slave modport is the datapath side.
interface nms_layer_scheduler_if #(
    parameter int LW  = 2,
    parameter int CWD = 5,
    parameter int IW  = 4
);
    logic           start_frame;
    logic           abort;
    logic           col_ready;
    logic           row_done;
    logic           check_done;
    logic           check_pass;
    logic           busy;
    logic           col_valid;
    logic [CWD-1:0] col_idx;
    logic           col_first;
    logic           col_last;
    logic [LW-1:0]  layer_idx;
    logic [IW-1:0]  iter_cnt;
    logic           last_iteration;
    logic           iter_done;
    logic           check_req;
    logic           done;
    logic           decode_ok;

    modport master (
        input  start_frame, abort, col_ready, row_done, check_done, check_pass,
        output busy, col_valid, col_idx, col_first, col_last, layer_idx, iter_cnt,
               last_iteration, iter_done, check_req, done, decode_ok
    );

    modport slave (
        output start_frame, abort, col_ready, row_done, check_done, check_pass,
        input  busy, col_valid, col_idx, col_first, col_last, layer_idx, iter_cnt,
               last_iteration, iter_done, check_req, done, decode_ok
    );
endinterface

// File: rtl/nms_layer_scheduler.sv
// Layer/column sequencer for the layered NMS LDPC decoder: streams column-block beats per layer,
// waits for each layer's write-back, counts iterations and ends the frame on parity pass or limit.
module nms_layer_scheduler #(
    parameter int ROWS     = 4,
    parameter int COLS     = 24,
    parameter int ITER_MAX = 10,
    parameter int LW       = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CWD      = $clog2(COLS),
    parameter int IW       = (ITER_MAX > 1) ? $clog2(ITER_MAX) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nms_layer_scheduler_if.master   bus
);
    localparam logic [CWD-1:0] COL_MAX   = CWD'(COLS - 1);
    localparam logic [LW-1:0]  LAYER_MAX = LW'(ROWS - 1);
    localparam logic [IW-1:0]  ITER_LAST = IW'(ITER_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ROW,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state_reg;
    logic [CWD-1:0] col_idx_reg;
    logic [LW-1:0]  layer_idx_reg;
    logic [IW-1:0]  iter_cnt_reg;
    logic           busy_reg;
    logic           col_valid_reg;
    logic           iter_done_reg;
    logic           check_req_reg;
    logic           done_reg;
    logic           decode_ok_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            col_idx_reg   <= '0;
            layer_idx_reg <= '0;
            iter_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            col_valid_reg <= 1'b0;
            iter_done_reg <= 1'b0;
            check_req_reg <= 1'b0;
            done_reg      <= 1'b0;
            decode_ok_reg <= 1'b0;
        end else begin
            iter_done_reg <= 1'b0;
            done_reg      <= 1'b0;
            // Abort beats every state transition, including a start in IDLE.
            if (bus.abort) begin
                state_reg     <= S_IDLE;
                col_idx_reg   <= '0;
                layer_idx_reg <= '0;
                iter_cnt_reg  <= '0;
                busy_reg      <= 1'b0;
                col_valid_reg <= 1'b0;
                check_req_reg <= 1'b0;
                decode_ok_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.start_frame) begin
                            col_idx_reg   <= '0;
                            layer_idx_reg <= '0;
                            iter_cnt_reg  <= '0;
                            decode_ok_reg <= 1'b0;
                            busy_reg      <= 1'b1;
                            col_valid_reg <= 1'b1;
                            state_reg     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (bus.col_ready) begin
                            if (col_idx_reg == COL_MAX) begin
                                col_idx_reg   <= '0;
                                col_valid_reg <= 1'b0;
                                state_reg     <= S_WAIT_ROW;
                            end else begin
                                col_idx_reg <= col_idx_reg + CWD'(1);
                            end
                        end
                    end
                    S_WAIT_ROW: begin
                        if (bus.row_done) begin
                            if (layer_idx_reg == LAYER_MAX) begin
                                layer_idx_reg <= '0;
                                iter_done_reg <= 1'b1;
                                check_req_reg <= 1'b1;
                                state_reg     <= S_CHECK;
                            end else begin
                                layer_idx_reg <= layer_idx_reg + LW'(1);
                                col_valid_reg <= 1'b1;
                                state_reg     <= S_ISSUE;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (bus.check_done) begin
                            check_req_reg <= 1'b0;
                            if (bus.check_pass || (iter_cnt_reg == ITER_LAST)) begin
                                decode_ok_reg <= bus.check_pass;
                                done_reg      <= 1'b1;
                                state_reg     <= S_DONE;
                            end else begin
                                iter_cnt_reg  <= iter_cnt_reg + IW'(1);
                                col_valid_reg <= 1'b1;
                                state_reg     <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        busy_reg      <= 1'b0;
                        col_valid_reg <= 1'b0;
                        check_req_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // First/last flags are gated by col_valid so idle beat outputs stay all-zero.
    assign bus.col_first      = col_valid_reg && (col_idx_reg == '0);
    assign bus.col_last       = col_valid_reg && (col_idx_reg == COL_MAX);
    assign bus.last_iteration = busy_reg && (iter_cnt_reg == ITER_LAST);

    assign bus.busy      = busy_reg;
    assign bus.col_valid = col_valid_reg;
    assign bus.col_idx   = col_idx_reg;
    assign bus.layer_idx = layer_idx_reg;
    assign bus.iter_cnt  = iter_cnt_reg;
    assign bus.iter_done = iter_done_reg;
    assign bus.check_req = check_req_reg;
    assign bus.done      = done_reg;
    assign bus.decode_ok = decode_ok_reg;
endmodule

// File: tb/tb_nms_layer_scheduler.sv
// Directed bench for nms_layer_scheduler: expected beats are queued at frame start and
// popped as the DUT emits them; frame-level results are checked at each frame end.
module tb_nms_layer_scheduler;
    localparam int ROWS     = 4;
    localparam int COLS     = 24;
    localparam int ITER_MAX = 10;
    localparam int LW       = 2;
    localparam int CWD      = 5;
    localparam int IW       = 4;

    logic clk;
    logic rst_n;

    nms_layer_scheduler_if #(.LW(LW), .CWD(CWD), .IW(IW)) bus ();

    nms_layer_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .ITER_MAX(ITER_MAX), .LW(LW), .CWD(CWD), .IW(IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int col;
        int layer;
        int iter;
    } beat_t;

    beat_t sb_q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    n_fail  = 0;
    bit    sb_en   = 1'b0;
    bit    stall_prev = 1'b0;
    int    held_idx   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every accepted beat must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            if (stall_prev) begin
                chk("hold_valid", bus.col_valid, 1);
                chk("hold_idx", bus.col_idx, held_idx);
            end
            stall_prev = bus.col_valid && !bus.col_ready;
            held_idx   = bus.col_idx;
            if (bus.col_valid && bus.col_ready) begin
                if (sb_q.size() == 0) begin
                    chk("extra_beat", bus.col_idx, 999);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("beat_col", bus.col_idx, e.col);
                    chk("beat_layer", bus.layer_idx, e.layer);
                    chk("beat_iter", bus.iter_cnt, e.iter);
                    chk("beat_first", bus.col_first, (e.col == 0));
                    chk("beat_last", bus.col_last, (e.col == COLS - 1));
                    chk("beat_last_iter", bus.last_iteration, (e.iter == ITER_MAX - 1));
                end
            end
        end
    end

    task automatic clear_inputs();
        bus.start_frame = 1'b0;
        bus.abort       = 1'b0;
        bus.row_done    = 1'b0;
        bus.check_done  = 1'b0;
        bus.check_pass  = 1'b0;
        bus.col_ready   = 1'b1;
    endtask

    // pass_iter < 0: never pass; abort_layer >= 0: abort while waiting on that global layer.
    task automatic run_frame(input string name, input int pass_iter, input bit toggle,
                             input bit spurious, input int abort_layer);
        int n_iters, n_layers, iters_seen, layers_acc, rd_cnt, ab_cnt, cyc;
        int got_ok, got_iter, got_busy;
        bit fin, ab_go, nxt_rd, nxt_cd, nxt_cp, nxt_st, nxt_ready;
        n_iters    = (pass_iter < 0) ? ITER_MAX : pass_iter + 1;
        n_layers   = (abort_layer >= 0) ? abort_layer + 1 : n_iters * ROWS;
        iters_seen = 0; layers_acc = 0; rd_cnt = 0; ab_cnt = 0; cyc = 0;
        got_ok = 0; got_iter = 0; got_busy = 0; fin = 0; ab_go = 0;
        for (int g = 0; g < n_layers; g++)
            for (int c = 0; c < COLS; c++)
                sb_q.push_back('{c, g % ROWS, g / ROWS});

        @(posedge clk); #1;
        clear_inputs();
        bus.start_frame = 1'b1;
        @(negedge clk);
        chk({name, "_busy_at_start"}, bus.busy, 0);
        @(posedge clk); #1;
        bus.start_frame = 1'b0;
        @(negedge clk);
        chk({name, "_busy_T1"}, bus.busy, 1);
        chk({name, "_valid_T1"}, bus.col_valid, 1);
        chk({name, "_idx_T1"}, bus.col_idx, 0);
        chk({name, "_decode_ok_clr"}, bus.decode_ok, 0);

        nxt_rd = 0; nxt_cd = 0; nxt_cp = 0; nxt_st = 0;
        nxt_ready = toggle ? 1'b0 : 1'b1;
        while (!fin && !ab_go && cyc < 6000) begin
            @(posedge clk); #1;
            bus.col_ready   = nxt_ready;
            bus.row_done    = nxt_rd;
            bus.check_done  = nxt_cd;
            bus.check_pass  = nxt_cp;
            bus.start_frame = nxt_st;
            @(negedge clk);
            cyc++;
            if (bus.iter_done) iters_seen++;
            if (bus.done) begin
                fin      = 1;
                got_ok   = bus.decode_ok;
                got_iter = bus.iter_cnt;
                got_busy = bus.busy;
            end
            nxt_rd = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) nxt_rd = 1;
            end
            if (ab_cnt > 0) begin
                ab_cnt--;
                if (ab_cnt == 0) ab_go = 1;
            end
            if (bus.col_valid && bus.col_ready && bus.col_last) begin
                if (layers_acc == abort_layer) ab_cnt = 2;
                else rd_cnt = 2;
                layers_acc++;
            end
            nxt_cd    = bus.check_req && !bus.check_done;
            nxt_cp    = nxt_cd && (iters_seen - 1 == pass_iter);
            nxt_ready = toggle ? !bus.col_ready : 1'b1;
            nxt_st    = spurious && bus.col_valid && (bus.col_idx == 5);
            if (spurious && bus.col_valid && (bus.col_idx == 5)) nxt_rd = 1;
        end

        if (abort_layer >= 0) begin
            chk({name, "_abort_reached"}, ab_go, 1);
            @(posedge clk); #1;
            clear_inputs();
            bus.abort = 1'b1;
            @(negedge clk);
            chk({name, "_pre_abort_layer"}, bus.layer_idx, abort_layer % ROWS);
            chk({name, "_pre_abort_iter"}, bus.iter_cnt, abort_layer / ROWS);
            @(posedge clk); #1;
            bus.abort = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk({name, "_abort_busy"}, bus.busy, 0);
                chk({name, "_abort_done"}, bus.done, 0);
                chk({name, "_abort_valid"}, bus.col_valid, 0);
                chk({name, "_abort_layer"}, bus.layer_idx, 0);
                chk({name, "_abort_iter"}, bus.iter_cnt, 0);
                chk({name, "_abort_ok"}, bus.decode_ok, 0);
            end
            chk({name, "_sb_empty"}, sb_q.size(), 0);
        end else begin
            chk({name, "_frame_end"}, fin, 1);
            chk({name, "_decode_ok"}, got_ok, (pass_iter >= 0));
            chk({name, "_iter_at_done"}, got_iter, n_iters - 1);
            chk({name, "_busy_at_done"}, got_busy, 1);
            chk({name, "_iter_done_pulses"}, iters_seen, n_iters);
            @(posedge clk); #1;
            clear_inputs();
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk({name, "_post_done"}, bus.done, 0);
                chk({name, "_post_busy"}, bus.busy, 0);
                chk({name, "_post_valid"}, bus.col_valid, 0);
                chk({name, "_ok_held"}, bus.decode_ok, (pass_iter >= 0));
            end
            chk({name, "_sb_empty"}, sb_q.size(), 0);
        end
        $display("frame %s done: beats_left=%0d cycles=%0d", name, sb_q.size(), cyc);
    endtask

    initial begin
        bit saw7;
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.col_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_check_req", bus.check_req, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset asserted mid-ISSUE at col_idx 7.
        @(posedge clk); #1;
        bus.start_frame = 1'b1;
        @(posedge clk); #1;
        bus.start_frame = 1'b0;
        saw7 = 0;
        for (int k = 0; k < 40 && !saw7; k++) begin
            @(negedge clk);
            if (bus.col_idx == 7) saw7 = 1;
        end
        chk("rst_mid_reached", saw7, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_valid", bus.col_valid, 0);
        chk("rst_mid_idx", bus.col_idx, 0);
        chk("rst_mid_first", bus.col_first, 0);
        chk("rst_mid_last", bus.col_last, 0);
        chk("rst_mid_layer", bus.layer_idx, 0);
        chk("rst_mid_iter", bus.iter_cnt, 0);
        chk("rst_mid_lastit", bus.last_iteration, 0);
        chk("rst_mid_decode_ok", bus.decode_ok, 0);
        $display("reset mid-issue applied");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_idle_busy", bus.busy, 0);
            chk("rst_idle_valid", bus.col_valid, 0);
        end
        sb_en = 1'b1;

        // Start coincident with abort in IDLE is dropped.
        @(posedge clk); #1;
        bus.start_frame = 1'b1;
        bus.abort       = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("abort_start_busy", bus.busy, 0);
        chk("abort_start_valid", bus.col_valid, 0);
        $display("abort with start in idle applied");

        run_frame("full", -1, 1'b0, 1'b0, -1);
        run_frame("pass2", 2, 1'b0, 1'b0, -1);
        run_frame("toggle", 0, 1'b1, 1'b0, -1);
        run_frame("abort", -1, 1'b0, 1'b0, ROWS + 2);
        run_frame("restart", 1, 1'b0, 1'b0, -1);
        run_frame("spurious", 0, 1'b0, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
